// File: rtl/ded_link_mesh_gen_if.sv
// Handshake and data bundle for ded_link_mesh_gen: frame request, operands and
// the mesh status/output words.
interface ded_link_mesh_gen_if #(
  parameter int unsigned DWIDTH = 36,
  parameter int unsigned COLS   = 3
);
  logic                       start;
  logic [DWIDTH-1:0]          a;
  logic [DWIDTH-1:0]          b;
  logic                       busy;
  logic                       done;
  logic                       out_valid;
  logic [COLS*2*DWIDTH-1:0]   out_data;

  modport master (output start, a, b, input busy, done, out_valid, out_data);
  modport slave  (input start, a, b, output busy, done, out_valid, out_data);
endinterface

// File: rtl/ded_link_mesh_gen.sv
// ROWS x COLS mesh of registered accumulate stages fed by a start/done frame
// sequencer; vertical links carry words down, horizontal links add the left neighbour.
module ded_link_mesh_gen #(
  parameter int unsigned DWIDTH    = 36,
  parameter int unsigned ROWS      = 7,
  parameter int unsigned COLS      = 3,
  parameter int unsigned FRAME_LEN = 256,
  parameter int unsigned CNT_W     = 16
) (
  input logic clk,
  input logic reset,
  ded_link_mesh_gen_if.slave bus
);
  localparam int unsigned W = 2 * DWIDTH;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               inj_vld_q;
  logic [ROWS-1:0]    vld_q;
  logic [W-1:0]       inj_w [COLS];
  logic [W-1:0]       v_w   [ROWS][COLS];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        if (cnt_q == CNT_W'(FRAME_LEN - 1)) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        // ROWS+1 cycles: one for the injection register plus ROWS mesh stages
        if (cnt_q == CNT_W'(ROWS)) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.busy = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign bus.done = (state_q == S_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      inj_vld_q <= 1'b0;
      vld_q     <= '0;
    end else begin
      inj_vld_q <= (state_q == S_RUN);
      vld_q[0]  <= inj_vld_q;
      for (int unsigned r = 1; r < ROWS; r++) begin
        vld_q[r] <= vld_q[r-1];
      end
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_col
    logic [W-1:0] inj_q;

    always_ff @(posedge clk) begin
      if (reset)                inj_q <= '0;
      else if (state_q == S_RUN) inj_q <= {bus.b, bus.a} + W'(c);
      else                      inj_q <= '0;
    end
    assign inj_w[c] = inj_q;

    for (genvar r = 0; r < ROWS; r++) begin : g_row
      logic [W-1:0] up, left, v_q, v_d;

      if (r == 0) begin : g_top
        assign up = inj_w[c];
      end else begin : g_mid
        assign up = v_w[r-1][c];
      end

      // Column 0 has no horizontal link, so it is a pure delay line
      if (c == 0) begin : g_edge
        assign left = '0;
      end else begin : g_link
        assign left = v_w[r][c-1];
      end

      assign v_d = up + left;

      always_ff @(posedge clk) begin
        if (reset) v_q <= '0;
        else       v_q <= v_d;
      end
      assign v_w[r][c] = v_q;
    end
  end

  assign bus.out_valid = vld_q[ROWS-1];

  always_comb begin
    bus.out_data = '0;
    for (int unsigned c = 0; c < COLS; c++) begin
      bus.out_data[c*W +: W] = v_w[ROWS-1][c];
    end
  end
endmodule
